// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Memory-stage load/store unit. Runs one req/gnt/rvalid bus
//            transaction per access and returns extended load data.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_valid_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            misalign_o,
    output logic            fault_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic            dbus_err_i,
    input  logic [XLEN-1:0] dbus_rdata_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_off;
    logic [2:0]      r_funct3;
    logic            r_fault;

    logic            w_size_h;
    logic            w_size_w;
    logic            w_misalign;
    logic            w_accept;
    logic            w_capture;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_load;

    assign w_size_h   = (funct3_i[1:0] == 2'b01);
    assign w_size_w   = funct3_i[1];
    assign w_misalign = lsu_valid_i & ((w_size_h & addr_i[0]) | (w_size_w & (|addr_i[1:0])));
    assign w_accept   = (r_state == IDLE) & lsu_valid_i & ~w_misalign & ~flush_i;
    assign w_capture  = (r_state == WAIT) & dbus_rvalid_i & ~flush_i;

    assign misalign_o = w_misalign & (r_state == IDLE);
    assign stall_o    = w_accept | (r_state == REQ) | (r_state == WAIT) | (r_state == DRAIN);
    assign dbus_req_o = (r_state == REQ);
    assign done_o     = (r_state == RESP);
    assign fault_o    = (r_state == RESP) & r_fault;

    // Lane placement for the outgoing access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << addr_i[1:0];
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata_i;
            end
        endcase
    end

    assign w_lane = dbus_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_load = w_lane;
        case (r_funct3)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b101:  w_load = {16'd0, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = REQ;
            REQ: begin
                if (dbus_gnt_i)   w_next = flush_i ? DRAIN : WAIT;
                else if (flush_i) w_next = IDLE;
            end
            WAIT: begin
                if (dbus_rvalid_i) w_next = flush_i ? IDLE : RESP;
                else if (flush_i)  w_next = DRAIN;
            end
            DRAIN: if (dbus_rvalid_i) w_next = IDLE;
            RESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= 4'd0;
            dbus_wdata_o <= '0;
            mem_rdata_o  <= '0;
            r_off        <= 2'd0;
            r_funct3     <= 3'd0;
            r_fault      <= 1'b0;
        end else begin
            if (w_accept) begin
                dbus_we_o    <= is_store_i;
                dbus_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                dbus_be_o    <= w_be;
                dbus_wdata_o <= w_wdata;
                r_off        <= addr_i[1:0];
                r_funct3     <= funct3_i;
            end
            if (w_capture) begin
                r_fault <= dbus_err_i;
                // Stores keep the previous load result visible to write-back
                if (!dbus_we_o)
                    mem_rdata_o <= dbus_err_i ? '0 : w_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu: vector table plus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, done_o, misalign_o, fault_o;
    logic [31:0] mem_rdata_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_gnt_i = 1'b0;
    logic        dbus_rvalid_i = 1'b0;
    logic        dbus_err_i = 1'b0;
    logic [31:0] dbus_rdata_i = '0;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid_i(lsu_valid_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .stall_o(stall_o), .done_o(done_o), .mem_rdata_o(mem_rdata_o),
        .misalign_o(misalign_o), .fault_o(fault_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_err_i(dbus_err_i), .dbus_rdata_i(dbus_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          gd;
        int          rd;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] exp;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    vec_t tbl[12];
    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every done_o pulse consumes one expected result
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("load_data", mem_rdata_o, e.rdata);
                chk("fault", fault_o, e.fault);
            end
        end
    end

    task automatic do_access(input vec_t v);
        @(negedge clk);
        lsu_valid_i = 1'b1; is_store_i = v.st; funct3_i = v.f3;
        addr_i = v.addr; wdata_i = v.wdata;
        #1;
        chk("misalign", misalign_o, v.mis);
        chk("stall_idle", stall_o, !v.mis);
        if (v.mis) begin
            repeat (2) begin
                @(negedge clk); #1;
                chk("mis_no_req", dbus_req_o, 0);
                chk("mis_no_stall", stall_o, 0);
                chk("mis_hold", misalign_o, 1);
            end
            lsu_valid_i = 1'b0;
            return;
        end
        sb_q.push_back('{v.exp, v.fault});
        @(negedge clk);
        for (int k = 0; k <= v.gd; k++) begin
            chk("req", dbus_req_o, 1);
            chk("stall_req", stall_o, 1);
            chk("bus_be", dbus_be_o, v.be);
            chk("bus_addr", dbus_addr_o, v.baddr);
            chk("bus_we", dbus_we_o, v.st);
            if (v.st) chk("bus_wdata", dbus_wdata_o, v.bwdata);
            if (k == v.gd) dbus_gnt_i = 1'b1;
            @(negedge clk);
            dbus_gnt_i = 1'b0;
        end
        chk("req_drop", dbus_req_o, 0);
        for (int k = 0; k <= v.rd; k++) begin
            chk("stall_wait", stall_o, 1);
            chk("done_early", done_o, 0);
            if (k == v.rd) begin
                dbus_rvalid_i = 1'b1; dbus_rdata_i = v.rdata; dbus_err_i = v.err;
            end
            @(negedge clk);
            dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = '0;
        end
        chk("done", done_o, 1);
        chk("stall_resp", stall_o, 0);
        lsu_valid_i = 1'b0;
        @(negedge clk);
        chk("done_pulse", done_o, 0);
    endtask

    task automatic drive_lw(input logic [31:0] a);
        lsu_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
        addr_i = a; wdata_i = '0;
    endtask

    initial begin
        //          st    f3      addr      wdata          rdata          err  gd rd mis   be       baddr     bwdata         exp            fault
        tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 0, 0, 1'b0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80AA55CC, 1'b0, 0, 0, 1'b0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80AA55CC, 1'b0, 1, 0, 1'b0, 4'b1000, 32'h100, 32'h0,        32'h00000080, 1'b0};
        tbl[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80AA55CC, 1'b0, 0, 1, 1'b0, 4'b1100, 32'h100, 32'h0,        32'hFFFF80AA, 1'b0};
        tbl[4]  = '{1'b1, 3'b000, 32'h201, 32'h12345678, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, 4'b0010, 32'h200, 32'h78787878, 32'hFFFF80AA, 1'b0};
        tbl[5]  = '{1'b1, 3'b001, 32'h202, 32'h12345678, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, 4'b1100, 32'h200, 32'h56785678, 32'hFFFF80AA, 1'b0};
        tbl[6]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b0, 0, 0, 1'b1, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b0};
        tbl[7]  = '{1'b1, 3'b001, 32'h101, 32'h0,        32'h0,        1'b0, 0, 0, 1'b1, 4'b0000, 32'h0,   32'h0,        32'h0,        1'b0};
        tbl[8]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 1'b0, 5, 2, 1'b0, 4'b0011, 32'h100, 32'h0,        32'h0000F00D, 1'b0};
        tbl[9]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h55555555, 1'b1, 0, 0, 1'b0, 4'b1111, 32'h104, 32'h0,        32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1'b0, 0, 0, 1'b0, 4'b0010, 32'h100, 32'h0,        32'h0000007F, 1'b0};
        tbl[11] = '{1'b1, 3'b010, 32'h30C, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 1, 1, 1'b0, 4'b1111, 32'h30C, 32'hCAFEF00D, 32'h0000007F, 1'b0};

        @(negedge clk);
        chk("rst_req", dbus_req_o, 0);
        chk("rst_we", dbus_we_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_addr", dbus_addr_o, 0);
        chk("rst_be", dbus_be_o, 0);
        chk("rst_wdata", dbus_wdata_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_stall", stall_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) do_access(tbl[i]);

        // Flush while waiting for the response: response must be swallowed
        @(negedge clk);
        drive_lw(32'h100);
        @(negedge clk);
        chk("fl_req", dbus_req_o, 1);
        dbus_gnt_i = 1'b1;
        @(negedge clk);
        dbus_gnt_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; lsu_valid_i = 1'b0;
        #1;
        chk("drain_stall", stall_o, 1);
        chk("drain_done", done_o, 0);
        dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h11111111;
        @(negedge clk);
        dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
        #1;
        chk("post_drain_stall", stall_o, 0);
        chk("post_drain_done", done_o, 0);
        chk("post_drain_rdata", mem_rdata_o, 32'h0000007F);
        do_access(tbl[0]);

        // Flush in REQ without grant: back to idle, no request left
        @(negedge clk);
        drive_lw(32'h100);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; lsu_valid_i = 1'b0;
        #1;
        chk("flreq_req", dbus_req_o, 0);
        chk("flreq_stall", stall_o, 0);

        // Asynchronous reset in REQ
        @(negedge clk);
        drive_lw(32'h100);
        @(negedge clk);
        chk("rstreq_req", dbus_req_o, 1);
        #2;
        lsu_valid_i = 1'b0; rst = 1'b1;
        #1;
        chk("rstreq_req_low", dbus_req_o, 0);
        chk("rstreq_stall", stall_o, 0);
        chk("rstreq_rdata", mem_rdata_o, 0);
        @(negedge clk);
        rst = 1'b0;
        do_access(tbl[3]);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit for the memory stage, directly upstream of write-back.
- Accepts one load or store per instruction from execute: effective address, store data, funct3.
- Runs a req/gnt/rvalid transaction on the data bus and stalls the pipeline until the response returns.
- Delivers the sign- or zero-extended load result on mem_rdata_o, which write-back selects for load instructions.
- Detects misaligned accesses and bus errors.

Parameters:
XLEN, 32, data/address width; only 32 is supported (byte-enable and lane logic are fixed at 4 lanes).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
lsu_valid_i  in  1  memory-stage instruction is a load or store
is_store_i  in  1  1 = store, 0 = load
funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  in  XLEN  effective byte address
wdata_i  in  XLEN  store data (rs2)
flush_i  in  1  kill the current instruction
stall_o  out  1  hold the pipeline
done_o  out  1  one-cycle pulse: access complete, result valid
mem_rdata_o  out  XLEN  extended load data, for write-back
misalign_o  out  1  misaligned-access exception (combinational)
fault_o  out  1  bus-error exception, asserted together with done_o
dbus_req_o  out  1  bus request
dbus_we_o  out  1  bus write enable
dbus_addr_o  out  XLEN  word-aligned address {addr[31:2],2'b00}
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  XLEN  lane-replicated store data
dbus_gnt_i  in  1  request accepted
dbus_rvalid_i  in  1  response valid (loads and stores)
dbus_err_i  in  1  response error, qualified by rvalid
dbus_rdata_i  in  XLEN  read data

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - dbus_req_o, dbus_we_o, done_o, fault_o = 0.
  - dbus_addr_o, dbus_be_o, dbus_wdata_o, mem_rdata_o = 0.
- Misalignment:
  - misalign = lsu_valid_i & ((size H & addr[0]) | (size W & addr[1:0]!=0)).
  - Size W is any funct3[1:0]=11 or 10.
  - misalign_o = misalign while state==IDLE, otherwise 0.
  - A misaligned access never issues a bus request and never stalls.
- Lane encoding:
  - Byte enables: B → 4'b0001<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111.
  - Store data: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
- States:
  - IDLE: if lsu_valid_i & ~misalign & ~flush_i, register the bus address, write enable, byte enables and write data; set dbus_req_o=1; go to REQ.
  - REQ: dbus_req_o=1 and all bus outputs held stable until gnt.
    - gnt → dbus_req_o=0, go to WAIT.
    - flush_i & ~gnt → dbus_req_o=0, go to IDLE.
    - flush_i & gnt → go to DRAIN.
  - WAIT: waiting for the response.
    - rvalid → go to RESP; capture mem_rdata_o (loads); fault_o=err.
    - flush_i & ~rvalid → go to DRAIN.
    - flush_i & rvalid → go to IDLE; no done_o.
  - DRAIN: discard the outstanding response; rvalid → IDLE; outputs unchanged.
  - RESP: done_o=1 for exactly one cycle, then IDLE unconditionally.
- Load extraction:
  - Byte lane = rdata >> (8*addr[1:0]) using the registered address.
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
  - A bus error loads mem_rdata_o = 0.
  - Stores leave mem_rdata_o unchanged.
- stall_o = (lsu_valid_i & ~misalign & ~flush_i & state==IDLE) | state∈{REQ,WAIT,DRAIN}.
  - stall_o is 0 in RESP, so the pipeline advances in the same cycle done_o pulses.
- Latency: minimum 4 cycles (IDLE, REQ+gnt, WAIT+rvalid, RESP); stall_o is high for 3 of them.
- Bus rules:
  - At most one outstanding transaction.
  - gnt is ignored outside REQ; rvalid is ignored in IDLE/REQ/RESP.
- Reset mid-transaction returns to IDLE immediately. The bus is assumed to be reset by the same rst.

Test Plan:
- LW hit: addr=0x100, gnt 1 cycle after req, rvalid next cycle with rdata=0xDEADBEEF → dbus_be_o=1111, done_o at cycle 3, mem_rdata_o=0xDEADBEEF, stall_o high cycles 0–2.
- LB/LBU lane: addr=0x103, rdata=0x80AA55CC → LB gives 0xFFFFFF80, LBU gives 0x00000080; LH addr=0x102 gives 0xFFFF80AA.
- SB/SH stores: SB addr=0x201, wdata=0x12345678 → be=0010, dbus_wdata_o=0x78787878, dbus_addr_o=0x200, dbus_we_o=1; SH addr=0x202 → be=1100, wdata=0x56785678.
- Misaligned: LW addr=0x102 → misalign_o=1 the same cycle, stall_o=0, dbus_req_o never asserted; SH addr=0x101 likewise.
- Backpressure/flush:
  - gnt withheld 5 cycles → bus outputs stable throughout, stall_o held.
  - flush_i in WAIT → DRAIN; subsequent rvalid produces no done_o; next access proceeds normally.
- Bus error and reset:
  - rvalid with err on LW → done_o & fault_o, mem_rdata_o=0.
  - rst asserted in REQ → dbus_req_o=0 immediately (asynchronous), state IDLE.
